// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared constants for the RV32M multiply/divide unit.
// Contents: funct3 op codes, FSM state encodings, write-enable polarity,
// default operand width and operand-signedness helpers.
package muldiv_unit_pkg;
  localparam int MD_XLEN = 32;
  localparam logic [2:0] MD_MUL    = 3'd0;
  localparam logic [2:0] MD_MULH   = 3'd1;
  localparam logic [2:0] MD_MULHSU = 3'd2;
  localparam logic [2:0] MD_MULHU  = 3'd3;
  localparam logic [2:0] MD_DIV    = 3'd4;
  localparam logic [2:0] MD_DIVU   = 3'd5;
  localparam logic [2:0] MD_REM    = 3'd6;
  localparam logic [2:0] MD_REMU   = 3'd7;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic ENABLE  = 1'b1;
  localparam logic DISABLE = 1'b0;
  // MUL yields only the low word, which is sign-agnostic, so it runs unsigned.
  function automatic logic op_signed_a(input logic [2:0] op);
    return op == MD_MULH || op == MD_MULHSU || op == MD_DIV || op == MD_REM;
  endfunction
  function automatic logic op_signed_b(input logic [2:0] op);
    return op == MD_MULH || op == MD_DIV || op == MD_REM;
  endfunction
endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: one combinational step of unsigned shift-add multiply or
// restoring divide.
// Ports:
//   div_i            1 = divide step, 0 = multiply step
//   acc_i / acc_o    2*W accumulator; mul: running product,
//                    div: {quotient, remainder}
//   opa_i / opa_o    mul: multiplicand (held), div: dividend (shifts left)
//   opb_i / opb_o    mul: multiplier (shifts right), div: divisor (held)
module muldiv_iter #(
  parameter int W = 32
) (
  input  logic           div_i,
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   opa_i,
  input  logic [W-1:0]   opb_i,
  output logic [2*W-1:0] acc_o,
  output logic [W-1:0]   opa_o,
  output logic [W-1:0]   opb_o
);
  logic [W:0] sum;
  logic [W:0] t;
  logic [W:0] trial;
  logic       ge;
  always_comb begin
    sum   = {1'b0, acc_i[2*W-1:W]} + (opb_i[0] ? {1'b0, opa_i} : '0);
    t     = {acc_i[W-1:0], opa_i[W-1]};
    // remainder < divisor before the shift, so t - divisor fits in W+1 bits
    // and its top bit is a clean borrow flag
    trial = t - {1'b0, opb_i};
    ge    = ~trial[W];
    acc_o = div_i ? {acc_i[2*W-2:W], ge, (ge ? trial[W-1:0] : t[W-1:0])}
                  : {sum, acc_i[W-1:1]};
    opa_o = div_i ? {opa_i[W-2:0], 1'b0} : opa_i;
    opb_o = div_i ? opb_i : {1'b0, opb_i[W-1:1]};
  end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with register-file write.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   start, op, src1, src2    request (sampled only in IDLE), funct3, operands
//   rd_num                   destination register; 0 suppresses the write
//   flush                    abort an operation still iterating
//   busy                     high from the cycle after accept through write
//   reg_we, dstreg_num,      one-cycle write strobe with register number
//   dstreg_data              and result; number/data hold otherwise
// Build option: MULDIV_EARLY_OUT_EN skips iteration for trivial operands.
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int XLEN   = MD_XLEN,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   src1,
  input  logic [XLEN-1:0]   src2,
  input  logic [REG_AW-1:0] rd_num,
  input  logic              flush,
  output logic              busy,
  output logic              reg_we,
  output logic [REG_AW-1:0] dstreg_num,
  output logic [XLEN-1:0]   dstreg_data
);
  logic [1:0]        state_q, state_d;
  logic [5:0]        cnt_q, cnt_d;
  logic [2*XLEN-1:0] acc_q, acc_d, acc_n;
  logic [XLEN-1:0]   opa_q, opa_d, opa_n;
  logic [XLEN-1:0]   opb_q, opb_d, opb_n;
  logic [2:0]        op_q;
  logic [REG_AW-1:0] rd_q;
  logic              sa_q, sb_q, b0_q;
  logic [XLEN-1:0]   a_raw_q;
  logic              done_q, reg_we_q;
  logic [REG_AW-1:0] dnum_q;
  logic [XLEN-1:0]   ddata_q;
  logic              take, sgn_a, sgn_b, neg;
  logic [XLEN-1:0]   abs_a, abs_b, quo, rem, result;
  logic [2*XLEN-1:0] prod;
  muldiv_iter #(.W(XLEN)) u_iter (
    .div_i (op_q[2]),
    .acc_i (acc_q),
    .opa_i (opa_q),
    .opb_i (opb_q),
    .acc_o (acc_n),
    .opa_o (opa_n),
    .opb_o (opb_n)
  );
  // done_q marks the write cycle; the FSM is already back in IDLE then,
  // but a new request must wait one more cycle.
  assign busy        = state_q != S_IDLE || done_q;
  assign reg_we      = reg_we_q;
  assign dstreg_num  = dnum_q;
  assign dstreg_data = ddata_q;
  always_comb begin
    take    = state_q == S_IDLE && !done_q && start && !flush;
    sgn_a   = op_signed_a(op) & src1[XLEN-1];
    sgn_b   = op_signed_b(op) & src2[XLEN-1];
    abs_a   = sgn_a ? -src1 : src1;
    abs_b   = sgn_b ? -src2 : src2;
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    if (take) begin
      cnt_d = '0;
      opa_d = abs_a;
      opb_d = abs_b;
`ifdef MULDIV_EARLY_OUT_EN
      // preload the unsigned magnitude so DONE applies the same corrections
      state_d = (src2 == '0 || src1 == '0 || (!op[2] && src2 == XLEN'(1))) ? S_DONE : S_CALC;
      acc_d   = (!op[2] && src2 == XLEN'(1)) ? {{XLEN{1'b0}}, abs_a} : '0;
`else
      state_d = S_CALC;
      acc_d   = '0;
`endif
    end else if (state_q == S_CALC) begin
      state_d = flush ? S_IDLE : (cnt_q == 6'(XLEN-1)) ? S_DONE : S_CALC;
      cnt_d   = cnt_q + 6'd1;
      acc_d   = acc_n;
      opa_d   = opa_n;
      opb_d   = opb_n;
    end else if (state_q == S_DONE) begin
      state_d = S_IDLE;
    end
    neg    = sa_q ^ sb_q;
    prod   = neg ? -acc_q : acc_q;
    quo    = neg ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    rem    = sa_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    // signed overflow falls out naturally: |q| = 2^31 negates to itself
    result = op_q == MD_MUL ? prod[XLEN-1:0]
           : !op_q[2]       ? prod[2*XLEN-1:XLEN]
           : b0_q           ? (op_q[1] ? a_raw_q : '1)
           : op_q[1]        ? rem : quo;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      b0_q     <= 1'b0;
      a_raw_q  <= '0;
      done_q   <= 1'b0;
      reg_we_q <= DISABLE;
      dnum_q   <= '0;
      ddata_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      done_q   <= state_q == S_DONE;
      reg_we_q <= (state_q == S_DONE && rd_q != '0) ? ENABLE : DISABLE;
      if (take) begin
        op_q    <= op;
        rd_q    <= rd_num;
        sa_q    <= sgn_a;
        sb_q    <= sgn_b;
        b0_q    <= src2 == '0;
        a_raw_q <= src1;
      end
      if (state_q == S_DONE && rd_q != '0) begin
        dnum_q  <= rd_q;
        ddata_q <= result;
      end
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  import muldiv_unit_pkg::*;
  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [31:0] cyc;
  } exp_t;
`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EO = 1'b1;
`else
  localparam bit EO = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  op = '0;
  logic [31:0] src1 = '0;
  logic [31:0] src2 = '0;
  logic [4:0]  rd_num = '0;
  logic        busy, reg_we;
  logic [4:0]  dstreg_num;
  logic [31:0] dstreg_data;
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        q[$];

  muldiv_unit #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src1(src1), .src2(src2),
    .rd_num(rd_num), .flush(flush), .busy(busy), .reg_we(reg_we),
    .dstreg_num(dstreg_num), .dstreg_data(dstreg_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endfunction

  // monitor: every observed write must match the oldest expected write
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (reg_we) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=rd%0d/%0h required=none", dstreg_num, dstreg_data);
      end else begin
        e = q.pop_front();
        chk("wr_num", 32'(dstreg_num), 32'(e.rd));
        chk("wr_data", dstreg_data, e.data);
        chk("wr_cycle", 32'(cyc), e.cyc);
      end
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic [31:0] e, input int poke);
    int lat;
    int n;
    lat = (EO && (b == 0 || a == 0 || (!o[2] && b == 1))) ? 2 : 34;
    @(posedge clk);
    #1;
    op = o; src1 = a; src2 = b; rd_num = rd; start = 1'b1;
    if (rd != 0) q.push_back('{rd, e, 32'(cyc + lat)});
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      if (n == poke) begin
        op = MD_MUL; src1 = 32'd1; src2 = 32'd1; rd_num = 5'd9; start = 1'b1;
      end else start = 1'b0;
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    chk("busy_len", 32'(n), 32'(lat));
  endtask

  task automatic abort_op(input bit use_rst);
    @(posedge clk);
    #1;
    op = MD_MUL; src1 = 32'd5; src2 = 32'd6; rd_num = 5'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(busy), 32'd1);
    if (use_rst) rst = 1'b1; else flush = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    flush = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_we", 32'(reg_we), 32'd0);
    if (use_rst) begin
      chk("rst_num", 32'(dstreg_num), 32'd0);
      chk("rst_data", dstreg_data, 32'd0);
    end
    repeat (40) @(posedge clk);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_we", 32'(reg_we), 32'd0);
    chk("reset_num", 32'(dstreg_num), 32'd0);
    chk("reset_data", dstreg_data, 32'd0);
    rst = 1'b0;
    issue(MD_MUL,    32'd7,        32'hFFFFFFFD, 5'd5,  32'hFFFFFFEB, 0);
    issue(MD_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6,  32'hFFFFFFFE, 0);
    issue(MD_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 5'd7,  32'h00000000, 0);
    issue(MD_MULHSU, 32'hFFFFFFFF, 32'd2,        5'd8,  32'hFFFFFFFF, 0);
    issue(MD_MUL,    32'h12345678, 32'h10,       5'd10, 32'h23456780, 0);
    issue(MD_MULHU,  32'h12345678, 32'h10,       5'd11, 32'h00000001, 0);
    issue(MD_MULH,   32'h80000000, 32'd1,        5'd12, 32'hFFFFFFFF, 0);
    issue(MD_MULHU,  32'h80000000, 32'd1,        5'd13, 32'h00000000, 0);
    issue(MD_DIV,    32'hFFFFFFF9, 32'd2,        5'd14, 32'hFFFFFFFD, 0);
    issue(MD_REM,    32'hFFFFFFF9, 32'd2,        5'd15, 32'hFFFFFFFF, 0);
    issue(MD_DIV,    32'd7,        32'hFFFFFFFE, 5'd16, 32'hFFFFFFFD, 0);
    issue(MD_REM,    32'd7,        32'hFFFFFFFE, 5'd17, 32'h00000001, 0);
    issue(MD_DIV,    32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h80000000, 0);
    issue(MD_REM,    32'h80000000, 32'hFFFFFFFF, 5'd19, 32'h00000000, 0);
    issue(MD_DIVU,   32'd123,      32'd0,        5'd20, 32'hFFFFFFFF, 0);
    issue(MD_REMU,   32'd5,        32'd0,        5'd21, 32'h00000005, 0);
    issue(MD_DIV,    32'hFFFFFFF9, 32'd0,        5'd22, 32'hFFFFFFFF, 0);
    issue(MD_REMU,   32'd100,      32'd7,        5'd23, 32'h00000002, 0);
    issue(MD_MUL,    32'd3,        32'd3,        5'd0,  32'h00000000, 0);
    issue(MD_DIVU,   32'd100,      32'd7,        5'd4,  32'h0000000E, 5);
    @(posedge clk);
    #1;
    op = MD_MUL; src1 = 32'd2; src2 = 32'd3; rd_num = 5'd2; start = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    flush = 1'b0;
    chk("flush_start_busy", 32'(busy), 32'd0);
    abort_op(1'b0);
    issue(MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd24, 32'hFFFFFFFE, 0);
    abort_op(1'b1);
    issue(MD_DIV,   32'hFFFFFFF9, 32'd2,        5'd25, 32'hFFFFFFFD, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end
endmodule
